rfg_axis_protocol_mc: RTL and testbench
=======================================

// Module: rfg_axis_protocol_mc
// PURPOSE
//  Parametrised successor of the byte-stream register-file protocol engine.
//  Decodes header/address/length commands from an AXIS byte slave and drives the rfg register bus.
//  Returns read data on an AXIS master, routed back to the requesting source port.
//  Adds over the previous generation:
//  - configurable address and length widths;
//  - pipelined reads with outstanding-read credit;
//  - read timeout with byte substitution;
//  - optional write acknowledge.
// PARAMETERS
//  ID_DEST_WIDTH  8   width of s_axis_tid / m_axis_tid / m_axis_tdest
//  ADDR_BYTES     1   address bytes after header (1..2), LSB first
//  LEN_BYTES      2   length bytes (1..2), LSB first
//  RBUF_AWIDTH    4   read buffer depth = 2**RBUF_AWIDTH bytes
//  READ_TIMEOUT   255 cycles waited for rfg_read_valid before substitution (>=2)
// PORTS
//  aclk               in  1              clock
//  areset             in  1              async reset, active-high
//  s_axis_tdata       in  8              command bytes
//  s_axis_tvalid      in  1
//  s_axis_tready      out 1
//  s_axis_tid         in  ID_DEST_WIDTH  source port; becomes m_axis_tdest
//  m_axis_tdata       out 8              response bytes
//  m_axis_tvalid      out 1
//  m_axis_tready      in  1
//  m_axis_tlast       out 1              last byte of a response
//  m_axis_tid         out ID_DEST_WIDTH  {0, header[7:4]} virtual channel
//  m_axis_tdest       out ID_DEST_WIDTH  latched s_axis_tid of the header byte
//  rfg_address        out 8*ADDR_BYTES   register address
//  rfg_write_value    out 8
//  rfg_write          out 1              one-cycle write strobe
//  rfg_write_last     out 1              set with the final write strobe
//  rfg_read           out 1              one-cycle read strobe
//  rfg_read_valid     in  1              read data valid; in order, latency >=1
//  rfg_read_value     in  8
//  timeout_count      out 8              saturating count of substituted bytes
//  debug_state        out 4              current FSM state encoding
// BEHAVIOUR
//  Reset: all outputs 0; FSM=HEADER(0); buffer emptied; outstanding/remaining counters 0.
//  Reset mid-operation aborts the command; no partial response is emitted.
//  Header byte: [0]=write, [1]=read, [2]=addr increment, [3]=ack request, [7:4]=vchannel.
//  - write has priority over read.
//  - A header with [1:0]==0 is consumed and ignored.
//  s_axis_tready=1 in HEADER, ADDR, LEN and WRITE; 0 in all other states.
//  FSM: HEADER -> ADDR (ADDR_BYTES beats) -> LEN (LEN_BYTES beats) -> WRITE | READ.
//  - READ -> DRAIN -> HEADER.
//  - WRITE -> ACK (if [3]) else HEADER; ACK -> HEADER.
//  - On header accept: latch m_axis_tdest<=s_axis_tid and m_axis_tid<=vchannel.
//  Length 0: no rfg strobes and no read data.
//  - Write with [3]: ACK still sent. Otherwise back to HEADER.
//  WRITE: each accepted byte produces rfg_write=1 one cycle later, with rfg_write_value=byte.
//  - rfg_write_last=1 on the final byte.
//  - Leave WRITE in the same cycle the final byte is accepted.
//  Address: rfg_address increments after each write/read strobe when [2]=1.
//  - Wraps modulo 2**(8*ADDR_BYTES).
//  READ: rfg_read pulses only when:
//  - issue_remaining>0, and
//  - buf_count + outstanding < 2**RBUF_AWIDTH.
//  - Back-to-back strobes are allowed.
//  - Go to DRAIN when the last strobe is issued.
//  outstanding: +1 per rfg_read, -1 per rfg_read_valid or timeout.
//  - Simultaneous +1/-1 leaves it unchanged.
//  - rfg_read_valid with outstanding==0 is discarded.
//  Timeout: a timer runs while outstanding>0 and resets on each rfg_read_valid.
//  - At READ_TIMEOUT, push 8'hEE in place of the oldest byte, decrement outstanding, timeout_count+1.
//  - timeout_count saturates at 255.
//  Buffer: FWFT; m_axis_tvalid = !empty; m_axis_tdata = head byte; pop on tvalid&&tready.
//  - The buffer never overflows, by credit.
//  - tdata/tid/tdest/tlast are held stable while tvalid&&!tready.
//  tlast=1 on the byte for which send_remaining==1.
//  DRAIN -> HEADER in the cycle the tlast byte handshakes.
//  ACK: present 8'hAC with tlast=1 until it handshakes.
// TESTING
//  1. Write: bytes 05,10,03,00,AA,BB,CC.
//     -> 3 write strobes: addr 10/11/12, data AA/BB/CC.
//     -> write_last on CC only; no m_axis traffic.
//  2. Write with ack: header 0D, tid=3, len 1, data 55.
//     -> one write strobe, then byte AC with tlast=1, tdest=3, tid=0.
//  3. Read: header 36, addr 20, len 5, read_valid latency 2, tready 50% random.
//     -> 5 bytes in order, tlast on the 5th, tid=3, addr 20..24.
//  4. Backpressure: RBUF_AWIDTH=4, len 20, tready=0 for 100 cycles.
//     -> rfg_read stops after 16 strobes; all 20 bytes delivered, no loss.
//  5. Timeout: READ_TIMEOUT=8, len 2, read_valid never asserted.
//     -> two EE bytes, tlast on the 2nd, timeout_count=2, FSM back in HEADER.
//  6. Edge cases: header 00 and read with len 0.
//     -> both ignored, no output.
//     Then assert areset during a read: outputs 0 at once.
//     -> a following write command executes correctly.

Source files
------------

// File: rtl/rfg_axis_protocol_mc.sv
// rfg_axis_protocol_mc: AXIS byte-command engine driving the rfg register bus, with credit-based pipelined reads
//  aclk/areset        clock, async active-high reset
//  s_axis_*           command bytes in (header, address, length, write data); tid names the source port
//  m_axis_*           read data / write ack out; tdest returns to the source port, tid carries the vchannel
//  rfg_*              register bus: address, write strobe/value/last, read strobe, read return
//  timeout_count      saturating count of read bytes replaced by 8'hEE
//  debug_state        FSM state encoding
module rfg_axis_protocol_mc #(
  parameter int ID_DEST_WIDTH = 8,
  parameter int ADDR_BYTES    = 1,
  parameter int LEN_BYTES     = 2,
  parameter int RBUF_AWIDTH   = 4,
  parameter int READ_TIMEOUT  = 255
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [ID_DEST_WIDTH-1:0]  s_axis_tid,
  output logic [7:0]                m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [ID_DEST_WIDTH-1:0]  m_axis_tid,
  output logic [ID_DEST_WIDTH-1:0]  m_axis_tdest,
  output logic [8*ADDR_BYTES-1:0]   rfg_address,
  output logic [7:0]                rfg_write_value,
  output logic                      rfg_write,
  output logic                      rfg_write_last,
  output logic                      rfg_read,
  input  logic                      rfg_read_valid,
  input  logic [7:0]                rfg_read_value,
  output logic [7:0]                timeout_count,
  output logic [3:0]                debug_state
);
  localparam int AW    = 8 * ADDR_BYTES;
  localparam int LW    = 8 * LEN_BYTES;
  localparam int DEPTH = 2 ** RBUF_AWIDTH;
  localparam int TW    = $clog2(READ_TIMEOUT + 1);
  localparam logic [1:0] AB_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] LB_LAST = 2'(LEN_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(READ_TIMEOUT - 1);
  typedef enum logic [3:0] {
    S_HEADER = 4'd0, S_ADDR = 4'd1, S_LEN = 4'd2, S_WRITE = 4'd3,
    S_READ = 4'd4, S_DRAIN = 4'd5, S_ACK = 4'd6
  } state_t;
  state_t state_q, state_d;
  logic [2:0] hdr_q;
  logic [1:0] beat_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] len_q, len_full, issue_q, send_q;
  logic [RBUF_AWIDTH:0] out_q, cnt_q;
  logic [RBUF_AWIDTH-1:0] wp_q, rp_q;
  logic [7:0] mem_q [DEPTH];
  logic [TW-1:0] timer_q;
  logic [7:0] tmo_q, wr_val_q;
  logic wr_q, wr_last_q;
  logic [ID_DEST_WIDTH-1:0] tid_q, tdest_q;
  logic s_acc, hdr_acc, wr_acc, buf_vld, pop, rv_acc, to, push, rd_fire;
  // hdr_q = {ack, inc, write}; a header that is neither write nor read never leaves HEADER
  always_comb begin
    s_acc    = s_axis_tvalid && s_axis_tready;
    hdr_acc  = s_acc && state_q == S_HEADER;
    wr_acc   = s_acc && state_q == S_WRITE;
    buf_vld  = cnt_q != '0;
    pop      = buf_vld && m_axis_tready;
    rv_acc   = rfg_read_valid && out_q != '0;
    to       = out_q != '0 && !rv_acc && timer_q == TO_LAST;
    push     = rv_acc || to;
    rd_fire  = state_q == S_READ && issue_q != '0 &&
               ({1'b0, cnt_q} + {1'b0, out_q}) < (RBUF_AWIDTH + 2)'(DEPTH);
    len_full = len_q | (LW'(s_axis_tdata) << {beat_q, 3'b000});
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) state_q <= S_HEADER;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HEADER: if (s_acc && s_axis_tdata[1:0] != 2'b00) state_d = S_ADDR;
      S_ADDR:   if (s_acc && beat_q == AB_LAST) state_d = S_LEN;
      S_LEN:    if (s_acc && beat_q == LB_LAST)
                  state_d = len_full == '0 ? (hdr_q[0] && hdr_q[2] ? S_ACK : S_HEADER)
                                           : (hdr_q[0] ? S_WRITE : S_READ);
      S_WRITE:  if (s_acc && issue_q == LW'(1)) state_d = hdr_q[2] ? S_ACK : S_HEADER;
      S_READ:   if (rd_fire && issue_q == LW'(1)) state_d = S_DRAIN;
      S_DRAIN:  if (pop && send_q == LW'(1)) state_d = S_HEADER;
      S_ACK:    if (m_axis_tready) state_d = S_HEADER;
      default:  state_d = S_HEADER;
    endcase
  end
  always_comb begin
    s_axis_tready   = !areset && state_q <= S_WRITE;
    m_axis_tvalid   = buf_vld || state_q == S_ACK;
    m_axis_tdata    = buf_vld ? mem_q[rp_q] : (state_q == S_ACK ? 8'hAC : 8'h00);
    m_axis_tlast    = buf_vld ? send_q == LW'(1) : state_q == S_ACK;
    m_axis_tid      = tid_q;
    m_axis_tdest    = tdest_q;
    rfg_address     = addr_q;
    rfg_write_value = wr_val_q;
    rfg_write       = wr_q;
    rfg_write_last  = wr_last_q;
    rfg_read        = rd_fire;
    timeout_count   = tmo_q;
    debug_state     = state_q;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      hdr_q     <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      issue_q   <= '0;
      send_q    <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      timer_q   <= '0;
      tmo_q     <= '0;
      wr_val_q  <= '0;
      wr_q      <= 1'b0;
      wr_last_q <= 1'b0;
      tid_q     <= '0;
      tdest_q   <= '0;
    end else begin
      wr_q      <= wr_acc;
      wr_last_q <= wr_acc && issue_q == LW'(1);
      if (wr_acc) wr_val_q <= s_axis_tdata;
      if ((wr_q || rd_fire) && hdr_q[2 - 1]) addr_q <= addr_q + AW'(1);
      if (hdr_acc) begin
        hdr_q   <= {s_axis_tdata[3], s_axis_tdata[2], s_axis_tdata[0]};
        tid_q   <= ID_DEST_WIDTH'(s_axis_tdata[7:4]);
        tdest_q <= s_axis_tid;
        beat_q  <= '0;
        addr_q  <= '0;
        len_q   <= '0;
      end
      if (s_acc && state_q == S_ADDR) begin
        addr_q <= addr_q | (AW'(s_axis_tdata) << {beat_q, 3'b000});
        beat_q <= beat_q == AB_LAST ? 2'd0 : beat_q + 2'd1;
      end
      if (s_acc && state_q == S_LEN) begin
        len_q   <= len_full;
        beat_q  <= beat_q + 2'd1;
        issue_q <= len_full;
        send_q  <= len_full;
      end
      if (wr_acc || rd_fire) issue_q <= issue_q - LW'(1);
      if (pop) send_q <= send_q - LW'(1);
      // credit: a strobe and a return/timeout in the same cycle cancel out
      out_q   <= out_q + (RBUF_AWIDTH + 1)'(rd_fire) - (RBUF_AWIDTH + 1)'(push);
      timer_q <= (out_q == '0 || push) ? '0 : timer_q + TW'(1);
      tmo_q   <= tmo_q + 8'(to && tmo_q != 8'hFF);
      wp_q    <= wp_q + RBUF_AWIDTH'(push);
      rp_q    <= rp_q + RBUF_AWIDTH'(pop);
      cnt_q   <= cnt_q + (RBUF_AWIDTH + 1)'(push) - (RBUF_AWIDTH + 1)'(pop);
    end
  // a timed-out byte takes the slot of the oldest outstanding read
  always_ff @(posedge aclk)
    if (push) mem_q[wp_q] <= rv_acc ? rfg_read_value : 8'hEE;
endmodule

// File: tb/tb_rfg_axis_protocol_mc.sv
// tb_rfg_axis_protocol_mc: scoreboard bench for rfg_axis_protocol_mc
module tb_rfg_axis_protocol_mc;
  typedef struct packed { logic [7:0] a; logic [7:0] d; logic l; } wr_t;
  typedef struct packed { logic [7:0] d; logic l; logic [7:0] id; logic [7:0] dst; } m_t;
  logic aclk = 1'b0, areset = 1'b1;
  logic [7:0] s_axis_tdata = '0, s_axis_tid = '0;
  logic s_axis_tvalid = 1'b0, s_axis_tready;
  logic [7:0] m_axis_tdata, m_axis_tid, m_axis_tdest;
  logic m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
  logic [7:0] rfg_address, rfg_write_value, rfg_read_value = '0, timeout_count;
  logic rfg_write, rfg_write_last, rfg_read, rfg_read_valid = 1'b0;
  logic [3:0] debug_state;
  wr_t exp_wr[$];
  m_t exp_m[$];
  logic [7:0] exp_rd[$];
  wr_t w;
  m_t m;
  int checks = 0, passes = 0, rd_cnt = 0, m_cnt = 0, rdy_mode = 0;
  logic rv_en = 1'b1;
  logic p0_v = 1'b0, p1_v = 1'b0;
  logic [7:0] p0_d = '0, p1_d = '0;
  rfg_axis_protocol_mc #(.ID_DEST_WIDTH(8), .ADDR_BYTES(1), .LEN_BYTES(2),
                         .RBUF_AWIDTH(4), .READ_TIMEOUT(8)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tid(s_axis_tid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .rfg_address(rfg_address), .rfg_write_value(rfg_write_value),
    .rfg_write(rfg_write), .rfg_write_last(rfg_write_last),
    .rfg_read(rfg_read), .rfg_read_valid(rfg_read_valid),
    .rfg_read_value(rfg_read_value), .timeout_count(timeout_count),
    .debug_state(debug_state)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic unexp(input string name);
    checks++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask
  // register bus model: read data = address ^ 5A, returned two cycles after the strobe
  always @(negedge aclk)
    if (areset) begin
      p0_v = 1'b0; p1_v = 1'b0; rfg_read_valid = 1'b0;
    end else begin
      rfg_read_valid = rv_en && p1_v;
      rfg_read_value = p1_d;
      p1_v = p0_v; p1_d = p0_d;
      p0_v = rfg_read; p0_d = rfg_address ^ 8'h5A;
    end
  initial forever begin
    @(posedge aclk); #1;
    m_axis_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  always @(negedge aclk)
    if (!areset) begin
      if (rfg_write) begin
        if (exp_wr.size() == 0) unexp("wr_strobe");
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", rfg_address, w.a);
          chk("wr_data", rfg_write_value, w.d);
          chk("wr_last", rfg_write_last, w.l);
        end
      end
      if (rfg_read) begin
        rd_cnt++;
        if (exp_rd.size() == 0) unexp("rd_strobe");
        else chk("rd_addr", rfg_address, exp_rd.pop_front());
      end
      if (m_axis_tvalid && m_axis_tready) begin
        m_cnt++;
        if (exp_m.size() == 0) unexp("m_byte");
        else begin
          m = exp_m.pop_front();
          chk("m_data", m_axis_tdata, m.d);
          chk("m_last", m_axis_tlast, m.l);
          chk("m_tid", m_axis_tid, m.id);
          chk("m_tdest", m_axis_tdest, m.dst);
        end
      end
    end
  task automatic send(input logic [7:0] d, input logic [7:0] id);
    int n = 0;
    logic ok = 1'b0;
    s_axis_tdata = d; s_axis_tid = id; s_axis_tvalid = 1'b1;
    while (!ok && n < 1000) begin
      @(negedge aclk);
      ok = s_axis_tready;
      n++;
    end
    if (!ok) unexp("s_accept_timeout");
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
  endtask
  task automatic cmd(input logic [7:0] h, input logic [7:0] id, input logic [7:0] a, input logic [15:0] n);
    send(h, id);
    if (h[1:0] != 2'b00) begin
      send(a, id); send(n[7:0], id); send(n[15:8], id);
    end
  endtask
  task automatic expect_read(input logic [7:0] h, input logic [7:0] id, input logic [7:0] a, input int n);
    logic [7:0] ad;
    for (int i = 0; i < n; i++) begin
      ad = h[2] ? a + 8'(i) : a;
      exp_rd.push_back(ad);
      exp_m.push_back({rv_en ? ad ^ 8'h5A : 8'hEE, 1'(i == n - 1), {4'h0, h[7:4]}, id});
    end
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_m.size() != 0 || exp_rd.size() != 0 || debug_state != 4'd0) && n < 3000) begin
      @(posedge aclk);
      n++;
    end
    repeat (3) @(posedge aclk);
    #1;
    chk(name, 32'(n < 3000), 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int r0, m0;
    #12;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_state", debug_state, 0);
    chk("rst_wr", rfg_write, 0);
    chk("rst_rd", rfg_read, 0);
    chk("rst_tmo", timeout_count, 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
    chk("idle_s_tready", s_axis_tready, 1);
    // 1: plain write with increment
    exp_wr.push_back({8'h10, 8'hAA, 1'b0});
    exp_wr.push_back({8'h11, 8'hBB, 1'b0});
    exp_wr.push_back({8'h12, 8'hCC, 1'b1});
    cmd(8'h05, 8'h01, 8'h10, 16'd3);
    send(8'hAA, 1); send(8'hBB, 1); send(8'hCC, 1);
    wait_idle("t1_done");
    // 2: write with ack
    exp_wr.push_back({8'h44, 8'h55, 1'b1});
    exp_m.push_back({8'hAC, 1'b1, 8'h00, 8'h03});
    cmd(8'h0D, 8'h03, 8'h44, 16'd1);
    send(8'h55, 3);
    wait_idle("t2_done");
    // 3: read, random backpressure
    rdy_mode = 1;
    expect_read(8'h36, 8'h05, 8'h20, 5);
    cmd(8'h36, 8'h05, 8'h20, 16'd5);
    wait_idle("t3_done");
    // 4: credit limit under full backpressure
    rdy_mode = 2;
    repeat (2) @(posedge aclk);
    #1;
    r0 = rd_cnt; m0 = m_cnt;
    expect_read(8'h16, 8'h07, 8'h40, 20);
    cmd(8'h16, 8'h07, 8'h40, 16'd20);
    repeat (100) @(posedge aclk);
    #1;
    chk("t4_credit_strobes", rd_cnt - r0, 16);
    chk("t4_stall_no_out", m_cnt - m0, 0);
    rdy_mode = 0;
    wait_idle("t4_done");
    chk("t4_bytes", m_cnt - m0, 20);
    chk("t4_strobes", rd_cnt - r0, 20);
    // 5: timeout substitution
    rv_en = 1'b0;
    expect_read(8'h02, 8'h02, 8'h30, 2);
    cmd(8'h02, 8'h02, 8'h30, 16'd2);
    wait_idle("t5_done");
    chk("t5_tmo_count", timeout_count, 2);
    chk("t5_state", debug_state, 0);
    rv_en = 1'b1;
    // 6: ignored header and zero-length read
    r0 = rd_cnt; m0 = m_cnt;
    cmd(8'h00, 8'h00, 8'h00, 16'd0);
    repeat (2) @(posedge aclk);
    #1;
    chk("t6_hdr00_state", debug_state, 0);
    cmd(8'h02, 8'h00, 8'h00, 16'd0);
    wait_idle("t6_len0_done");
    chk("t6_no_reads", rd_cnt - r0, 0);
    chk("t6_no_bytes", m_cnt - m0, 0);
    // 6: reset during a read
    rdy_mode = 2;
    repeat (2) @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) exp_rd.push_back(8'h60 + 8'(i));
    cmd(8'h06, 8'h02, 8'h60, 16'd4);
    repeat (12) @(posedge aclk);
    #1;
    chk("t6_pre_rst_valid", m_axis_tvalid, 1);
    areset = 1'b1;
    #1;
    chk("t6_rst_m_tvalid", m_axis_tvalid, 0);
    chk("t6_rst_rd", rfg_read, 0);
    chk("t6_rst_state", debug_state, 0);
    chk("t6_rst_tmo", timeout_count, 0);
    chk("t6_rst_tdest", m_axis_tdest, 0);
    chk("t6_rst_s_tready", s_axis_tready, 0);
    exp_rd.delete();
    exp_m.delete();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    rdy_mode = 0;
    exp_wr.push_back({8'h80, 8'h11, 1'b0});
    exp_wr.push_back({8'h80, 8'h22, 1'b1});
    cmd(8'h01, 8'h04, 8'h80, 16'd2);
    send(8'h11, 4); send(8'h22, 4);
    wait_idle("t6_post_rst_write");
    chk("t6_post_no_bytes", exp_m.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
